// File: rtl/cr_had_pkg.sv
// Shared types for the IU-side HAD debug responder: FSM states, one-hot entry causes,
// and the mapping from a latched cause to the HAD ack/occur pulses.
package cr_had_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_HALT = 3'd2,
        ST_DBG  = 3'd3,
        ST_EXIT = 3'd4
    } dbg_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 5'b00000;
    localparam logic [CAUSE_W-1:0] CAUSE_JDB   = 5'b00001;
    localparam logic [CAUSE_W-1:0] CAUSE_DR    = 5'b00010;
    localparam logic [CAUSE_W-1:0] CAUSE_INST  = 5'b00100;
    localparam logic [CAUSE_W-1:0] CAUSE_MEM   = 5'b01000;
    localparam logic [CAUSE_W-1:0] CAUSE_TRACE = 5'b10000;

    typedef struct packed {
        logic adr;
        logic dr;
        logic inst_bkpt;
        logic data_bkpt;
        logic trace;
    } dbg_ack_t;

    // One ack/occur strobe per entry cause
    function automatic dbg_ack_t cause_to_ack(input logic [CAUSE_W-1:0] cause);
        dbg_ack_t ack;
        ack.adr       = (cause == CAUSE_JDB);
        ack.dr        = (cause == CAUSE_DR);
        ack.inst_bkpt = (cause == CAUSE_INST);
        ack.data_bkpt = (cause == CAUSE_MEM);
        ack.trace     = (cause == CAUSE_TRACE);
        return ack;
    endfunction

endpackage

// File: rtl/cr_iu_had_dbg_tmr.sv
// Saturating debug-entry timeout counter; expire_c flags the count reaching ENTRY_TIMEOUT.
module cr_iu_had_dbg_tmr #(
    parameter int unsigned ENTRY_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ENTRY_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = (cnt == TIMEOUT_VAL);

endmodule

// File: rtl/cr_iu_had_dbg_resp.sv
// IU responder to HAD debug requests: drains the pipe, enters/leaves debug mode, acks causes.
// Optional feature macro: CR_IU_DBG_DPC_SNAP_EN (adds iu_retire_next_pc input and iu_had_dpc output).
module cr_iu_had_dbg_resp
    import cr_had_pkg::*;
#(
    parameter int unsigned ENTRY_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic        cpuclk,
    input  logic        cpurst_b,
    input  logic        had_iu_xx_jdbreq,
    input  logic        had_iu_dr_set_req,
    input  logic        had_iu_mem_bkpt_req,
    input  logic        had_iu_trace_req,
    input  logic        had_yy_xx_exit_dbg,
    input  logic        iu_retire_vld,
    input  logic        iu_retire_bkpt_inst,
    input  logic        iu_retire_chgflw,
    input  logic [31:0] iu_retire_dst_pc,
    input  logic        iu_pipe_idle,
`ifdef CR_IU_DBG_DPC_SNAP_EN
    input  logic [31:0] iu_retire_next_pc,
    output logic [31:0] iu_had_dpc,
`endif
    output logic        iu_yy_xx_dbgon,
    output logic        iu_dbg_halt_req,
    output logic        iu_dbg_restart,
    output logic        iu_had_adr_dbg_ack,
    output logic        iu_had_dr_dbg_ack,
    output logic        iu_had_inst_bkpt_occur_vld,
    output logic        iu_had_data_bkpt_occur_vld,
    output logic        iu_had_trace_occur_vld,
    output logic        iu_had_xx_bkpt_inst,
    output logic        iu_had_chgflw_vld,
    output logic [31:0] iu_had_chgflw_dst_pc
);

    dbg_state_e         state, next_state;
    logic [CAUSE_W-1:0] cause, cause_nxt, req_cause;
    dbg_ack_t           ack_q, ack_nxt;
    logic               tmr_expire_c;
    logic               chgflw_hit;

    cr_iu_had_dbg_tmr #(
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_tmr (
        .clk      (cpuclk),
        .rst_n    (cpurst_b),
        .clr      (state == ST_IDLE),
        .en       (state == ST_PEND),
        .expire_c (tmr_expire_c)
    );

    // Entry-cause priority: retiring sync causes beat level requests, DR beats async
    always_comb begin
        req_cause = CAUSE_NONE;
        if (iu_retire_vld && iu_retire_bkpt_inst) begin
            req_cause = CAUSE_INST;
        end else if (iu_retire_vld && had_iu_mem_bkpt_req) begin
            req_cause = CAUSE_MEM;
        end else if (iu_retire_vld && had_iu_trace_req) begin
            req_cause = CAUSE_TRACE;
        end else if (had_iu_dr_set_req) begin
            req_cause = CAUSE_DR;
        end else if (had_iu_xx_jdbreq) begin
            req_cause = CAUSE_JDB;
        end
    end

    // Next-state and cause latch; only the async cause may be forced in on timeout
    always_comb begin
        next_state = state;
        cause_nxt  = cause;
        case (state)
            ST_IDLE: begin
                if (req_cause != CAUSE_NONE) begin
                    next_state = ST_PEND;
                    cause_nxt  = req_cause;
                end
            end
            ST_PEND: begin
                if (iu_pipe_idle || ((cause == CAUSE_JDB) && tmr_expire_c)) begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: next_state = ST_DBG;
            ST_DBG: begin
                if (had_yy_xx_exit_dbg) begin
                    next_state = ST_EXIT;
                end
            end
            ST_EXIT: begin
                next_state = ST_IDLE;
                cause_nxt  = CAUSE_NONE;
            end
            default: begin
                next_state = ST_IDLE;
                cause_nxt  = CAUSE_NONE;
            end
        endcase
    end

    assign ack_nxt    = (next_state == ST_HALT) ? cause_to_ack(cause) : '0;
    assign chgflw_hit = iu_retire_vld && iu_retire_chgflw && !iu_yy_xx_dbgon && !iu_dbg_halt_req;

    // State register plus outputs registered from the upcoming state
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state                <= ST_IDLE;
            cause                <= CAUSE_NONE;
            ack_q                <= '0;
            iu_yy_xx_dbgon       <= 1'b0;
            iu_dbg_halt_req      <= 1'b0;
            iu_dbg_restart       <= 1'b0;
            iu_had_chgflw_vld    <= 1'b0;
            iu_had_chgflw_dst_pc <= 32'h0;
        end else begin
            state                <= next_state;
            cause                <= cause_nxt;
            ack_q                <= ack_nxt;
            iu_yy_xx_dbgon       <= (next_state == ST_DBG) || (next_state == ST_EXIT);
            iu_dbg_halt_req      <= (next_state != ST_IDLE);
            iu_dbg_restart       <= (next_state == ST_EXIT);
            iu_had_chgflw_vld    <= chgflw_hit;
            if (chgflw_hit) begin
                iu_had_chgflw_dst_pc <= iu_retire_dst_pc;
            end
        end
    end

`ifdef CR_IU_DBG_DPC_SNAP_EN
    // Resume PC captured as the request is accepted
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            iu_had_dpc <= 32'h0;
        end else if ((state == ST_IDLE) && (next_state == ST_PEND)) begin
            iu_had_dpc <= (iu_retire_vld && iu_retire_chgflw) ? iu_retire_dst_pc
                                                               : iu_retire_next_pc;
        end
    end
`endif

    assign iu_had_adr_dbg_ack         = ack_q.adr;
    assign iu_had_dr_dbg_ack          = ack_q.dr;
    assign iu_had_inst_bkpt_occur_vld = ack_q.inst_bkpt;
    assign iu_had_data_bkpt_occur_vld = ack_q.data_bkpt;
    assign iu_had_trace_occur_vld     = ack_q.trace;
    assign iu_had_xx_bkpt_inst        = ack_q.inst_bkpt;

endmodule
